ring_seq_ctrl: RTL and testbench
================================

Name: ring_seq_ctrl

Overview:
Sequencing controller for the W-bit ring counter datapath, driving the counter's parallel-load value (I) and its select input (0 = load I, 1 = rotate).
Accepts a start request carrying a seed pattern and a step count. It loads the seed, rotates exactly `steps` times, supports pause and abort, then pulses done.
Holds the counter frozen when not rotating by reloading a shadow copy every cycle. Optionally checks the counter output against that shadow.

Parameters:
W, 4, ring width in bits
CNT_W, 8, step-count width; max run = 2^CNT_W-1 rotations
RESET_PAT, 4'b0001, shadow/counter pattern after reset (W bits)
ROT_LEFT, 0, 0 = rotate right {Y[0],Y[W-1:1]}; 1 = rotate left {Y[W-2:0],Y[W-1]}; must match the counter instance

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-low reset (0 at posedge = reset)
start  input  1  request pulse/level, sampled only in IDLE
seed  input  W  pattern to load, captured with start
steps  input  CNT_W  number of rotations, captured with start
pause  input  1  level; freezes rotation while high
abort  input  1  level; terminates sequence without done
ring_Y  input  W  counter output (used only with RING_CHECK_EN)
ring_sel  output  1  to counter select: 0 = load ring_I, 1 = rotate
ring_I  output  W  to counter parallel input
busy  output  1  high in LOAD/RUN/PAUSE
done  output  1  one-cycle pulse in DONE
shadow  output  W  expected counter contents
mismatch  output  1  sticky check flag

Behaviour:
- Moore FSM, one-hot or binary (implementer's choice). States: IDLE, LOAD, RUN, PAUSE, DONE.
- Outputs are decoded from state and registers only. No combinational input-to-output path.
- Reset (reset=0 at posedge):
  - state=IDLE, shadow=RESET_PAT, remaining=0, mismatch=0.
  - Resulting outputs: ring_sel=0, ring_I=RESET_PAT, busy=0, done=0.
  - Reset mid-sequence discards the run immediately.
- IDLE: ring_sel=0, ring_I=shadow, so the counter is held.
  - If start=1 and abort=0: latch seed into seed_q, latch steps into remaining, go to LOAD.
  - start && abort in IDLE: stay IDLE.
- LOAD (exactly 1 cycle): ring_sel=0, ring_I=seed_q, busy=1.
  - At the edge: shadow<=seed_q.
  - Next state: DONE if remaining==0, else PAUSE if pause, else RUN.
- RUN: ring_sel=1, busy=1.
  - At each edge: shadow rotates per ROT_LEFT, remaining<=remaining-1.
  - Next state: DONE if remaining==1, else PAUSE if pause, else RUN.
- PAUSE: ring_sel=0, ring_I=shadow, busy=1; remaining unchanged.
  - Next state: RUN when pause=0.
- DONE (1 cycle): done=1, busy=0, ring_sel=0, ring_I=shadow. Next state: IDLE.
  - A start arriving during DONE is ignored; it must be re-presented in IDLE.
- abort=1 in LOAD/RUN/PAUSE: next state IDLE, no done pulse. Shadow keeps its current value.
  - Priority order: reset > abort > completion > pause.
- Latency: start sampled at edge k -> done high in cycle [k+steps+1, k+steps+2), plus one cycle per PAUSE cycle.
- Counter final value equals seed rotated (steps mod W) positions.
- start, seed and steps are ignored while busy.

Optional Feature:
Macro RING_CHECK_EN.
- Defined:
  - Each cycle, except the first cycle after reset deasserts, compare ring_Y with shadow.
  - Any inequality sets mismatch<=1 at the next edge.
  - mismatch is sticky and cleared only by reset or by an accepted start.
- Undefined: mismatch tied 0; ring_Y unused.

Decomposition:
- Shared package (ring_pkg):
  - state encoding constants ST_IDLE, ST_LOAD, ST_RUN, ST_PAUSE, ST_DONE;
  - SEL_LOAD=0 and SEL_ROT=1;
  - rotate function rot1(pattern, dir).
- One natural sub-module: ring_shadow (shadow register with load/rotate/hold controls). It is reusable by other ring-based blocks.
- The FSM stays in the top.

Test Plan:
- Reset=0 for 2 cycles, then release -> ring_sel=0, ring_I=0001, busy=0, done=0, mismatch=0; counter held at 0001.
- start with seed=1000, steps=3 (right) -> LOAD, then RUN; Y: 1000, 0100, 0010, 0001; done pulses exactly once at edge k+4; then IDLE holds 0001.
- steps=0, seed=0110 -> LOAD only; done at k+1; Y=0110 and held.
- seed=1000, steps=5, pause high for 2 cycles after the 2nd rotation -> Y frozen at 0010 during pause; done at k+8; final Y=0100.
- abort during RUN after 1 rotation of seed 1000 -> IDLE next edge, no done, Y held at 0100; a new start while busy is ignored.
- RING_CHECK_EN defined, counter ring_Y forced to 1111 for 1 cycle mid-RUN -> mismatch=1 and stays 1; next accepted start clears it.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared definitions for ring-counter control blocks: state encoding, select codes
// and a single-step rotate helper usable for any ring width up to RING_MAX_W-1.
package ring_pkg;

  localparam int RING_MAX_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } ring_state_t;

  localparam logic SEL_LOAD = 1'b0;
  localparam logic SEL_ROT  = 1'b1;

  // Rotate the low w bits of pattern by one place; dir=1 rotates left, dir=0 right.
  function automatic logic [RING_MAX_W-1:0] rot1(input logic [RING_MAX_W-1:0] pattern,
                                                 input int w, input logic dir);
    logic [RING_MAX_W-1:0] r;
    int src;
    r = '0;
    for (int i = 0; i < RING_MAX_W; i++) begin
      if (i < w) begin
        if (dir) src = (i == 0) ? (w - 1) : (i - 1);
        else     src = (i == w - 1) ? 0 : (i + 1);
        r[i] = pattern[src];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_shadow.sv
// Shadow copy of a ring counter: parallel load, single-step rotate, or hold.
// Synchronous active-low reset returns it to RESET_PAT.
module ring_shadow
  import ring_pkg::*;
#(
  parameter int          W         = 4,
  parameter logic [W-1:0] RESET_PAT = 4'b0001,
  parameter bit          ROT_LEFT  = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         rot,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  logic [RING_MAX_W-1:0] ext;
  logic [RING_MAX_W-1:0] rext;
  logic                  unused_hi;

  always_comb begin
    ext        = '0;
    ext[W-1:0] = q;
    rext       = rot1(ext, W, ROT_LEFT);
  end

  assign unused_hi = ^rext[RING_MAX_W-1:W];

  always_ff @(posedge clk) begin
    if (!reset)    q <= RESET_PAT;
    else if (load) q <= din;
    else if (rot)  q <= rext[W-1:0];
  end

endmodule

// File: rtl/ring_seq_ctrl.sv
// Sequencer for a W-bit ring counter: load seed, rotate `steps` times, pause/abort, pulse done.
// Optional counter-vs-shadow checking is built when RING_CHECK_EN is defined.
module ring_seq_ctrl
  import ring_pkg::*;
#(
  parameter int           W         = 4,
  parameter int           CNT_W     = 8,
  parameter logic [W-1:0] RESET_PAT = 4'b0001,
  parameter bit           ROT_LEFT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     seed,
  input  logic [CNT_W-1:0] steps,
  input  logic             pause,
  input  logic             abort,
  input  logic [W-1:0]     ring_Y,
  output logic             ring_sel,
  output logic [W-1:0]     ring_I,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     shadow,
  output logic             mismatch
);

  ring_state_t      state, nxt;
  logic [W-1:0]     seed_q;
  logic [CNT_W-1:0] remaining;
  logic             accept;

  assign accept = (state == ST_IDLE) && start && !abort;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
    end else begin
      state <= nxt;
      if (accept)               remaining <= steps;
      else if (state == ST_RUN) remaining <= remaining - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) seed_q <= seed;
  end

  // abort outranks completion, completion outranks pause
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (accept) nxt = ST_LOAD;
      ST_LOAD: begin
        if (abort)                nxt = ST_IDLE;
        else if (remaining == '0) nxt = ST_DONE;
        else if (pause)           nxt = ST_PAUSE;
        else                      nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort)                      nxt = ST_IDLE;
        else if (remaining == CNT_W'(1)) nxt = ST_DONE;
        else if (pause)                 nxt = ST_PAUSE;
        else                            nxt = ST_RUN;
      end
      ST_PAUSE: begin
        if (abort)       nxt = ST_IDLE;
        else if (!pause) nxt = ST_RUN;
      end
      ST_DONE:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ring_sel = SEL_LOAD;
    ring_I   = shadow;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_LOAD: begin
        ring_I = seed_q;
        busy   = 1'b1;
      end
      ST_RUN: begin
        ring_sel = SEL_ROT;
        busy     = 1'b1;
      end
      ST_PAUSE: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // The counter rotates whenever RUN drives SEL_ROT, including an aborting edge,
  // so the shadow follows it there too.
  ring_shadow #(
    .W        (W),
    .RESET_PAT(RESET_PAT),
    .ROT_LEFT (ROT_LEFT)
  ) u_shadow (
    .clk  (clk),
    .reset(reset),
    .load (state == ST_LOAD),
    .rot  (state == ST_RUN),
    .din  (seed_q),
    .q    (shadow)
  );

`ifdef RING_CHECK_EN
  logic chk_en;

  // The counter is not reset, so its value is unknown for the first cycle after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      chk_en   <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      chk_en <= 1'b1;
      if (accept)                           mismatch <= 1'b0;
      else if (chk_en && (ring_Y != shadow)) mismatch <= 1'b1;
    end
  end
`else
  logic unused_ring_y;
  assign unused_ring_y = ^ring_Y;
  assign mismatch      = 1'b0;
`endif

endmodule

// File: tb/tb_ring_seq_ctrl.sv
// Directed bench for ring_seq_ctrl driving a behavioural 4-bit right-rotating ring counter.
module tb_ring_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] seed;
  logic [7:0] steps;
  logic       pause;
  logic       abort;
  logic [3:0] ring_Y;
  logic       ring_sel;
  logic [3:0] ring_I;
  logic       busy;
  logic       done;
  logic [3:0] shadow;
  logic       mismatch;

  logic [3:0] y;
  logic       corrupt = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) y <= ring_sel ? {y[0], y[3:1]} : ring_I;
  assign ring_Y = corrupt ? 4'b1111 : y;

  ring_seq_ctrl #(.W(4), .CNT_W(8), .RESET_PAT(4'b0001), .ROT_LEFT(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .steps(steps),
    .pause(pause), .abort(abort), .ring_Y(ring_Y), .ring_sel(ring_sel),
    .ring_I(ring_I), .busy(busy), .done(done), .shadow(shadow), .mismatch(mismatch)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; seed = '0; steps = '0; pause = 1'b0; abort = 1'b0;
    tick(); tick();
    reset = 1'b1;
    chk("rst_sel", ring_sel, 0);
    chk("rst_I", ring_I, 4'b0001);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mm", mismatch, 0);
    tick();
    chk("rst_y", y, 4'b0001);

    // seed 1000, 3 steps
    start = 1'b1; seed = 4'b1000; steps = 8'd3;
    tick();
    start = 1'b0;
    chk("t1_load_I", ring_I, 4'b1000);
    chk("t1_load_busy", busy, 1);
    chk("t1_load_sel", ring_sel, 0);
    tick();
    chk("t1_y0", y, 4'b1000);
    chk("t1_run_sel", ring_sel, 1);
    tick();
    chk("t1_y1", y, 4'b0100);
    tick();
    chk("t1_y2", y, 4'b0010);
    chk("t1_nodone", done, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_done_busy", busy, 0);
    chk("t1_y3", y, 4'b0001);
    start = 1'b1; seed = 4'b0110; steps = 8'd0;
    tick();
    start = 1'b0;
    chk("t1_idle_done", done, 0);
    chk("t1_done_start_ign", busy, 0);
    chk("t1_idle_I", ring_I, 4'b0001);
    tick();
    chk("t1_hold_y", y, 4'b0001);

    // zero steps
    start = 1'b1; seed = 4'b0110; steps = 8'd0;
    tick();
    start = 1'b0;
    chk("t2_load_I", ring_I, 4'b0110);
    tick();
    chk("t2_done", done, 1);
    chk("t2_y", y, 4'b0110);
    tick();
    chk("t2_idle_done", done, 0);
    chk("t2_hold_I", ring_I, 4'b0110);
    tick();
    chk("t2_hold_y", y, 4'b0110);

    // 5 steps with 2 pause cycles
    start = 1'b1; seed = 4'b1000; steps = 8'd5;
    tick();
    start = 1'b0;
    tick();
    chk("t3_y0", y, 4'b1000);
    tick();
    chk("t3_y1", y, 4'b0100);
    pause = 1'b1;
    tick();
    chk("t3_pause_y", y, 4'b0010);
    chk("t3_pause_sel", ring_sel, 0);
    chk("t3_pause_busy", busy, 1);
    start = 1'b1; seed = 4'b1111; steps = 8'd1;
    tick();
    start = 1'b0;
    chk("t3_pause_y2", y, 4'b0010);
    pause = 1'b0;
    tick();
    chk("t3_resume_sel", ring_sel, 1);
    chk("t3_resume_y", y, 4'b0010);
    tick();
    chk("t3_y3", y, 4'b0001);
    tick();
    chk("t3_y4", y, 4'b1000);
    chk("t3_nodone", done, 0);
    tick();
    chk("t3_done", done, 1);
    chk("t3_final_y", y, 4'b0100);
    tick();
    chk("t3_idle_done", done, 0);
    chk("t3_hold_I", ring_I, 4'b0100);

    // abort after one rotation, with a competing start while busy
    start = 1'b1; seed = 4'b1000; steps = 8'd6;
    tick();
    start = 1'b0;
    tick();
    chk("t4_y0", y, 4'b1000);
    abort = 1'b1; start = 1'b1; seed = 4'b1111; steps = 8'd2;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_done", done, 0);
    chk("t4_abort_y", y, 4'b0100);
    tick();
    chk("t4_hold_y", y, 4'b0100);
    chk("t4_hold_shadow", shadow, 4'b0100);
    chk("t4_no_done", done, 0);
    chk("t4_idle_busy", busy, 0);

`ifdef RING_CHECK_EN
    start = 1'b1; seed = 4'b1000; steps = 8'd4;
    tick();
    start = 1'b0;
    tick();
    chk("t5_pre_mm", mismatch, 0);
    corrupt = 1'b1;
    tick();
    corrupt = 1'b0;
    chk("t5_mm_set", mismatch, 1);
    tick(); tick(); tick(); tick();
    chk("t5_mm_sticky", mismatch, 1);
    start = 1'b1; seed = 4'b0001; steps = 8'd1;
    tick();
    start = 1'b0;
    chk("t5_mm_clear", mismatch, 0);
    tick(); tick(); tick();
    chk("t5_mm_stays_clear", mismatch, 0);
`endif

    // reset in the middle of a run
    start = 1'b1; seed = 4'b1000; steps = 8'd3;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_I", ring_I, 4'b0001);
    chk("t6_rst_sel", ring_sel, 0);
    tick();
    chk("t6_rst_y", y, 4'b0001);
    chk("t6_rst_mm", mismatch, 0);
    tick();
    chk("t6_no_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
